// File: rtl/qbus_master.sv
// Q-bus master sequencer: DATI, DATO and DATIO cycles with RPLY timeout
// and DMA bus release. All outputs are registered and advance only on ce.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   ce                 clock enable for all state
//   req/we/rmw/byte_op CPU cycle request, direction, read-modify-write, byte
//   addr/wdata         CPU address and write data
//   rdata/done/berr    read data, end-of-cycle pulse, bus-error pulse
//   addr_o/data_o      bus address and write data
//   data_i/rply        bus read data and slave reply
//   sync/din/dout/wtbt bus strobes; bsy mirrors sync
//   dmr/dmgo/sack      DMA request, grant offer, acknowledge
module qbus_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 63,
  parameter int ADDR_SETUP = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              req,
  input  logic              we,
  input  logic              rmw,
  input  logic              byte_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              berr,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              sync,
  output logic              din,
  output logic              dout,
  output logic              wtbt,
  output logic              bsy,
  input  logic              rply,
  input  logic              dmr,
  output logic              dmgo,
  input  logic              sack
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD, S_GAP,
    S_WR, S_END, S_OFFER, S_HELD
  } state_t;

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW =
    (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP + 1) : 1;
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT);
  localparam logic [SW-1:0] AS_LD = SW'(ADDR_SETUP);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_scnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_rmw;
  logic              r_byte;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr_o;
  logic [DATA_W-1:0] r_data_o;
  logic              r_done;
  logic              r_berr;
  logic              r_sync;
  logic              r_din;
  logic              r_dout;
  logic              r_wtbt;
  logic              r_dmgo;

  state_t            w_nxt;
  logic [CW-1:0]     w_cnt;
  logic [SW-1:0]     w_scnt;
  logic              w_lat;
  logic              w_rd_ld;
  logic              w_wr_ld;
  logic              w_wait;
  logic              w_fin;
  logic              w_to;
  logic              w_bus;
  logic              w_byte;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_nxt   = r_state;
    w_cnt   = r_cnt;
    w_scnt  = r_scnt;
    w_lat   = 1'b0;
    w_rd_ld = 1'b0;
    w_wr_ld = 1'b0;
    w_wait  = 1'b0;
    w_fin   = 1'b0;
    w_to    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // the done cycle ignores req so a held req is not re-served
        if (dmr) begin
          w_nxt = S_OFFER;
        end else if (req && !r_done) begin
          w_nxt  = S_ADDR;
          w_lat  = 1'b1;
          w_scnt = AS_LD;
        end
      end
      S_ADDR: begin
        if (r_scnt == SW'(1)) begin
          w_cnt = TO_LD;
          if (r_rmw || !r_we) begin
            w_nxt = S_RD;
          end else begin
            w_nxt   = S_WR;
            w_wr_ld = 1'b1;
          end
        end else begin
          w_scnt = r_scnt - 1'b1;
        end
      end
      S_RD: begin
        if (rply) begin
          w_rd_ld = 1'b1;
          w_nxt   = r_rmw ? S_GAP : S_END;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_GAP: begin
        if (!rply) begin
          w_nxt   = S_WR;
          w_wr_ld = 1'b1;
          w_cnt   = TO_LD;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_WR: begin
        if (rply) w_nxt = S_END;
        else w_wait = 1'b1;
      end
      S_END: begin
        if (!rply) begin
          w_nxt = S_IDLE;
          w_fin = 1'b1;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_OFFER: begin
        if (sack) w_nxt = S_HELD;
        else if (!dmr) w_nxt = S_IDLE;
      end
      S_HELD: begin
        if (!sack) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
    // one shared watchdog for every phase that waits on rply
    if (w_wait) begin
      if (TIMEOUT != 0 && r_cnt == CW'(1)) begin
        w_to  = 1'b1;
        w_nxt = S_IDLE;
      end else begin
        w_cnt = r_cnt - 1'b1;
      end
    end
  end

  assign w_bus  = (w_nxt == S_ADDR) | (w_nxt == S_RD) |
                  (w_nxt == S_GAP)  | (w_nxt == S_WR);
  assign w_byte = w_lat ? byte_op : r_byte;
  assign w_addr = w_lat ? addr : r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_scnt   <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_rmw    <= 1'b0;
      r_byte   <= 1'b0;
      r_rdata  <= '0;
      r_addr_o <= '0;
      r_data_o <= '0;
      r_done   <= 1'b0;
      r_berr   <= 1'b0;
      r_sync   <= 1'b0;
      r_din    <= 1'b0;
      r_dout   <= 1'b0;
      r_wtbt   <= 1'b0;
      r_dmgo   <= 1'b0;
    end else if (ce) begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_scnt  <= w_scnt;
      if (w_lat) begin
        r_addr <= addr;
        r_we   <= we;
        r_rmw  <= rmw;
        r_byte <= byte_op;
      end
      if (w_rd_ld) r_rdata <= data_i;
      r_sync   <= w_bus;
      r_din    <= (w_nxt == S_RD);
      r_dout   <= (w_nxt == S_WR);
      r_wtbt   <= w_bus & w_byte;
      r_addr_o <= w_bus ? w_addr : '0;
      r_data_o <= w_wr_ld ? wdata :
                  ((w_nxt == S_WR) ? r_data_o : '0);
      r_done   <= w_fin | w_to;
      r_berr   <= w_to;
      r_dmgo   <= (w_nxt == S_OFFER);
    end
  end

  assign rdata  = r_rdata;
  assign done   = r_done;
  assign berr   = r_berr;
  assign addr_o = r_addr_o;
  assign data_o = r_data_o;
  assign sync   = r_sync;
  assign bsy    = r_sync;
  assign din    = r_din;
  assign dout   = r_dout;
  assign wtbt   = r_wtbt;
  assign dmgo   = r_dmgo;

endmodule

// File: tb/tb_qbus_master.sv
// Testbench for qbus_master: directed and random bus cycles
// against a cycle-count model with a reactive slave.
module tb_qbus_master;
  localparam int AS  = 1;
  localparam int TO  = 5;
  localparam int AS2 = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        rmw = 1'b0;
  logic        byte_op = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] data_i = '0;
  logic        rply = 1'b0;
  logic        dmr = 1'b0;
  logic        sack = 1'b0;
  logic [15:0] rdata, addr_o, data_o;
  logic        done, berr, sync, din, dout, wtbt, bsy, dmgo;

  logic        req2 = 1'b0;
  logic        rply2 = 1'b0;
  logic        dmr2 = 1'b0;
  logic        sack2 = 1'b0;
  logic [15:0] rdata2, addr_o2, data_o2;
  logic        done2, berr2, sync2, din2, dout2, wtbt2, bsy2, dmgo2;

  int total = 0;
  int bad = 0;

  int          o_lat, o_dn, o_bn, o_rise, o_sn;
  int          o_fs, o_fdi, o_fdo, o_din, o_dout;
  logic        o_bad_w, o_bad_a, o_bad_d, o_bd, o_after;
  logic [2:0]  o_strb;
  logic [15:0] o_rd;

  always #5 clk = ~clk;

  qbus_master #(
    .ADDR_W(16), .DATA_W(16),
    .TIMEOUT(TO), .ADDR_SETUP(AS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .req(req), .we(we), .rmw(rmw), .byte_op(byte_op),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .berr(berr),
    .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
    .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .bsy(bsy), .rply(rply),
    .dmr(dmr), .dmgo(dmgo), .sack(sack)
  );

  qbus_master #(
    .ADDR_W(16), .DATA_W(16),
    .TIMEOUT(0), .ADDR_SETUP(AS2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .req(req2), .we(we), .rmw(rmw), .byte_op(byte_op),
    .addr(addr), .wdata(wdata), .rdata(rdata2),
    .done(done2), .berr(berr2),
    .addr_o(addr_o2), .data_o(data_o2), .data_i(data_i),
    .sync(sync2), .din(din2), .dout(dout2),
    .wtbt(wtbt2), .bsy(bsy2), .rply(rply2),
    .dmr(dmr2), .dmgo(dmgo2), .sack(sack2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // op: 0 DATI, 1 DATO, 2 DATIO. The slave answers each strobe
  // phase after d1 (first) / d2 (second) extra cycles.
  task automatic bus_cycle(input int op, input logic bo,
      input logic [15:0] a, input logic [15:0] wd,
      input logic [15:0] rv, input int d1, input int d2);
    int k, seen, ph;
    logic psync;
    o_lat = 0; o_dn = 0; o_bn = 0; o_rise = 0; o_sn = 0;
    o_fs = 0; o_fdi = 0; o_fdo = 0; o_din = 0; o_dout = 0;
    o_bad_w = 0; o_bad_a = 0; o_bad_d = 0; o_bd = 0;
    o_strb = '0; o_rd = '0;
    psync = 0; seen = 0; ph = 0; k = 0;
    req = 1; we = (op == 1); rmw = (op == 2);
    byte_op = bo; addr = a; wdata = wd; rply = 0;
    while (k < 300 && o_lat == 0) begin
      step();
      k++;
      if (sync && !psync) o_rise++;
      psync = sync;
      if (sync) begin
        o_sn++;
        if (o_fs == 0) o_fs = k;
        if (addr_o !== a) o_bad_a = 1;
        if (wtbt !== bo) o_bad_w = 1;
      end
      if (din) begin
        o_din++;
        if (o_fdi == 0) o_fdi = k;
      end
      if (dout) begin
        o_dout++;
        if (o_fdo == 0) o_fdo = k;
        if (data_o !== wd) o_bad_d = 1;
      end
      if (done) o_dn++;
      if (berr) o_bn++;
      if (done) begin
        o_lat = k; o_bd = berr;
        o_strb = {sync, din, dout};
        o_rd = rdata; req = 0;
      end
      data_i = 16'($urandom);
      if (din || dout) begin
        seen++;
        if (seen == ((ph == 0) ? d1 : d2) + 1) begin
          rply = 1;
          if (din) data_i = rv;
        end
      end else begin
        if (seen > 0) ph++;
        seen = 0;
        rply = 0;
      end
    end
    req = 0;
    rply = 0;
    step();
    o_after = done | berr;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) step();
    total++;
    if ({rdata, addr_o, data_o, done, berr, sync, din,
         dout, wtbt, bsy, dmgo} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%h/%h ctl=%b exp=0",
        rdata, addr_o, data_o,
        {done, berr, sync, din, dout, wtbt, bsy, dmgo});
    end
    reset_n = 1;
    repeat (2) step();
    total++;
    if ({sync, done, dmgo} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=000",
        {sync, done, dmgo});
    end
  endtask

  task automatic test_dati();
    bus_cycle(0, 0, 16'o177716, 16'h0, 16'o123456, 2, 0);
    total++;
    if (o_lat != AS + 5) begin
      bad++;
      $display("FAIL dati_latency got=%0d exp=%0d",
        o_lat, AS + 5);
    end
    total++;
    if (o_fs != 1 || o_fdi - o_fs != AS) begin
      bad++;
      $display("FAIL dati_setup got=%0d/%0d exp=1/%0d",
        o_fs, o_fdi - o_fs, AS);
    end
    total++;
    if (o_rd !== 16'o123456) begin
      bad++;
      $display("FAIL dati_rdata got=%o exp=%o",
        o_rd, 16'o123456);
    end
    total++;
    if (o_dn != 1 || o_bn != 0 || o_after !== 1'b0) begin
      bad++;
      $display("FAIL dati_done got=%0d/%0d/%b exp=1/0/0",
        o_dn, o_bn, o_after);
    end
    total++;
    if (o_din != 3 || o_bad_a) begin
      bad++;
      $display("FAIL dati_strobes got=%0d/%b exp=3/0",
        o_din, o_bad_a);
    end
  endtask

  task automatic test_dato();
    bus_cycle(1, 1, 16'o1001, 16'h00A5, 16'h0, 1, 0);
    total++;
    if (o_lat != AS + 4) begin
      bad++;
      $display("FAIL dato_latency got=%0d exp=%0d",
        o_lat, AS + 4);
    end
    total++;
    if (o_bad_w || o_bad_d || o_bad_a) begin
      bad++;
      $display("FAIL dato_bus got=w%b d%b a%b exp=000",
        o_bad_w, o_bad_d, o_bad_a);
    end
    total++;
    if (o_fdo - o_fs != AS || o_dout != 2 || o_din != 0) begin
      bad++;
      $display("FAIL dato_strobes got=%0d/%0d/%0d exp=%0d/2/0",
        o_fdo - o_fs, o_dout, o_din, AS);
    end
    total++;
    if (o_dn != 1 || o_bn != 0) begin
      bad++;
      $display("FAIL dato_done got=%0d/%0d exp=1/0", o_dn, o_bn);
    end
  endtask

  task automatic test_datio();
    bus_cycle(2, 0, 16'o1234, 16'h4321, 16'h1234, 1, 1);
    total++;
    if (o_rise != 1 || o_sn != AS + 5) begin
      bad++;
      $display("FAIL datio_sync got=%0d/%0d exp=1/%0d",
        o_rise, o_sn, AS + 5);
    end
    total++;
    if (o_fdo - o_fdi != 3 || o_din != 2 || o_dout != 2) begin
      bad++;
      $display("FAIL datio_order got=%0d/%0d/%0d exp=3/2/2",
        o_fdo - o_fdi, o_din, o_dout);
    end
    total++;
    if (o_lat != AS + 7 || o_dn != 1) begin
      bad++;
      $display("FAIL datio_done got=%0d/%0d exp=%0d/1",
        o_lat, o_dn, AS + 7);
    end
    total++;
    if (o_rd !== 16'h1234 || o_bad_d) begin
      bad++;
      $display("FAIL datio_data got=%h/%b exp=1234/0",
        o_rd, o_bad_d);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] prev;
    prev = rdata;
    bus_cycle(0, 0, 16'($urandom), 16'h0,
      16'($urandom), 99, 0);
    total++;
    if (o_din != TO || o_lat != AS + TO + 1) begin
      bad++;
      $display("FAIL timeout_rd got=%0d/%0d exp=%0d/%0d",
        o_din, o_lat, TO, AS + TO + 1);
    end
    total++;
    if (o_bd !== 1'b1 || o_bn != 1 || o_strb !== 3'b000) begin
      bad++;
      $display("FAIL timeout_berr got=%b/%0d/%b exp=1/1/000",
        o_bd, o_bn, o_strb);
    end
    total++;
    if (o_rd !== prev || o_after !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rdata got=%h/%b exp=%h/0",
        o_rd, o_after, prev);
    end
    bus_cycle(1, 0, 16'($urandom), 16'($urandom),
      16'h0, 99, 0);
    total++;
    if (o_dout != TO || o_bd !== 1'b1 || o_dn != 1) begin
      bad++;
      $display("FAIL timeout_wr got=%0d/%b/%0d exp=%0d/1/1",
        o_dout, o_bd, o_dn, TO);
    end
    bus_cycle(0, 0, 16'($urandom), 16'h0,
      16'hBEEF, TO - 1, 0);
    total++;
    if (o_lat != AS + TO + 2 || o_bn != 0 ||
        o_rd !== 16'hBEEF) begin
      bad++;
      $display("FAIL timeout_edge got=%0d/%0d/%h exp=%0d/0/beef",
        o_lat, o_bn, o_rd, AS + TO + 2);
    end
  endtask

  task automatic test_dma();
    logic ok;
    dmr = 1;
    step();
    total++;
    if (dmgo !== 1'b1) begin
      bad++;
      $display("FAIL dma_withdraw_offer got=%b exp=1", dmgo);
    end
    dmr = 0;
    step();
    step();
    total++;
    if (dmgo !== 1'b0 || sync !== 1'b0) begin
      bad++;
      $display("FAIL dma_withdraw got=%b/%b exp=0/0", dmgo, sync);
    end
    req = 1; we = 0; rmw = 0; byte_op = 1;
    addr = 16'o172340; dmr = 1;
    step();
    total++;
    if (dmgo !== 1'b1 || sync !== 1'b0) begin
      bad++;
      $display("FAIL dma_offer got=%b/%b exp=1/0", dmgo, sync);
    end
    sack = 1;
    dmr = 0;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({sync, din, dout, wtbt, dmgo, done} !== '0 ||
          addr_o !== '0 || data_o !== '0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL dma_held got=%b/%h/%h exp=0/0/0",
        {sync, din, dout, wtbt, dmgo, done}, addr_o, data_o);
    end
    sack = 0;
    step();
    total++;
    if (sync !== 1'b0 || dmgo !== 1'b0) begin
      bad++;
      $display("FAIL dma_release got=%b/%b exp=0/0", sync, dmgo);
    end
    bus_cycle(0, 1, 16'o172340, 16'h0, 16'h5A5A, 1, 0);
    total++;
    if (o_lat != AS + 4 || o_rd !== 16'h5A5A || o_dn != 1) begin
      bad++;
      $display("FAIL dma_pending got=%0d/%h/%0d exp=%0d/5a5a/1",
        o_lat, o_rd, o_dn, AS + 4);
    end
  endtask

  task automatic test_ce();
    logic [15:0] v;
    logic ok;
    int k;
    v = 16'($urandom);
    req = 1; we = 0; rmw = 0; byte_op = 0;
    addr = 16'o157000; rply = 0;
    k = 0;
    do begin
      step();
      k++;
    end while (!din && k < 10);
    total++;
    if (din !== 1'b1) begin
      bad++;
      $display("FAIL ce_start got=%b exp=1", din);
    end
    rply = 1; data_i = v; ce = 0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (din !== 1'b1 || sync !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ce_freeze got=%b/%b exp=1/1", din, sync);
    end
    ce = 1;
    step();
    total++;
    if (din !== 1'b0 || rdata !== v) begin
      bad++;
      $display("FAIL ce_resume got=%b/%h exp=0/%h", din, rdata, v);
    end
    rply = 0;
    step();
    ce = 0; req = 0;
    ok = (done === 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ce_done_hold got=%b exp=1", done);
    end
    ce = 1;
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL ce_done_clear got=%b exp=0", done);
    end
  endtask

  task automatic test_random();
    int op, d1, d2, lat;
    logic bo;
    logic [15:0] a, wd, rv, erd;
    for (int n = 0; n < 20; n++) begin
      op = int'($urandom_range(2, 0));
      bo = 1'($urandom);
      a = 16'($urandom);
      wd = 16'($urandom);
      rv = 16'($urandom);
      d1 = int'($urandom_range(TO - 1, 0));
      d2 = int'($urandom_range(TO - 1, 0));
      erd = (op == 1) ? rdata : rv;
      lat = (op == 2) ? AS + 5 + d1 + d2 : AS + 3 + d1;
      bus_cycle(op, bo, a, wd, rv, d1, d2);
      total++;
      if (o_lat != lat || o_dn != 1 || o_bn != 0) begin
        bad++;
        $display("FAIL rand%0d_timing op=%0d got=%0d/%0d/%0d exp=%0d/1/0",
          n, op, o_lat, o_dn, o_bn, lat);
      end
      total++;
      if (o_rd !== erd || o_bad_a || o_bad_w || o_bad_d ||
          o_rise != 1) begin
        bad++;
        $display("FAIL rand%0d_bus op=%0d got=%h a%b w%b d%b r%0d exp=%h",
          n, op, o_rd, o_bad_a, o_bad_w, o_bad_d, o_rise, erd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    req = 1; we = 1; rmw = 0; byte_op = 1;
    addr = 16'o164000; wdata = 16'hC3C3; rply = 0;
    k = 0;
    do begin
      step();
      k++;
    end while (!dout && k < 10);
    total++;
    if (dout !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_wr got=%b exp=1", dout);
    end
    #2 reset_n = 0;
    #1;
    total++;
    if ({sync, din, dout, wtbt, bsy, done, berr, dmgo} !== '0 ||
        addr_o !== '0 || data_o !== '0 || rdata !== '0) begin
      bad++;
      $display("FAIL rstmid_async got=%b/%h/%h/%h exp=0",
        {sync, din, dout, wtbt, bsy, done, berr, dmgo},
        addr_o, data_o, rdata);
    end
    req = 0;
    step();
    reset_n = 1;
    step();
    bus_cycle(0, 0, 16'o177560, 16'h0, 16'h0F0F, 1, 0);
    total++;
    if (o_lat != AS + 4 || o_rd !== 16'h0F0F || o_dn != 1 ||
        o_bn != 0) begin
      bad++;
      $display("FAIL rstmid_clean got=%0d/%h/%0d/%0d exp=%0d/0f0f/1/0",
        o_lat, o_rd, o_dn, o_bn, AS + 4);
    end
  endtask

  task automatic test_no_timeout();
    int nd, ndone, fs, fd;
    nd = 0; ndone = 0; fs = 0; fd = 0;
    we = 0; rmw = 0; byte_op = 0; addr = 16'o177776;
    req2 = 1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (sync2 && fs == 0) fs = i;
      if (din2) begin
        nd++;
        if (fd == 0) fd = i;
      end
      if (done2 || berr2) ndone++;
    end
    total++;
    if (nd != 60 - AS2 || ndone != 0) begin
      bad++;
      $display("FAIL notimeout_wait got=%0d/%0d exp=%0d/0",
        nd, ndone, 60 - AS2);
    end
    total++;
    if (fs != 1 || fd - fs != AS2) begin
      bad++;
      $display("FAIL notimeout_setup got=%0d/%0d exp=1/%0d",
        fs, fd - fs, AS2);
    end
    req2 = 0;
  endtask

  initial begin
    test_reset();
    test_dati();
    test_dato();
    test_datio();
    test_timeout();
    test_dma();
    test_ce();
    test_random();
    test_reset_mid();
    test_no_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
